// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller: memory op encoding,
// controller states and per-width byte-mask bases.
package dmem_access_ctrl_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] data_t;

  typedef enum logic [2:0] {
    MEM_NO, MEM_B, MEM_H, MEM_W, MEM_D, MEM_UB, MEM_UH, MEM_UW
  } mem_op_enum;

  typedef enum logic [1:0] {
    ST_IDLE, ST_REQ, ST_WAIT, ST_DONE
  } dmem_ctrl_state_enum;

  localparam logic [7:0] MASK_BASE_B = 8'h01;
  localparam logic [7:0] MASK_BASE_H = 8'h03;
  localparam logic [7:0] MASK_BASE_W = 8'h0F;
  localparam logic [7:0] MASK_BASE_D = 8'hFF;

  function automatic logic [7:0] mask_base(input mem_op_enum op);
    case (op)
      MEM_B, MEM_UB: return MASK_BASE_B;
      MEM_H, MEM_UH: return MASK_BASE_H;
      MEM_W, MEM_UW: return MASK_BASE_W;
      MEM_D:         return MASK_BASE_D;
      default:       return 8'h00;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_op_enum op, input logic [2:0] off);
    case (op)
      MEM_H, MEM_UH: return off[0] != 1'b0;
      MEM_W, MEM_UW: return off[1:0] != 2'b00;
      MEM_D:         return off != 3'b000;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_align.sv
// mem_align_unit: store lane alignment / byte mask and load extraction with
// sign or zero extension for a 64-bit data bus.
import dmem_access_ctrl_pkg::*;

module mem_align_unit #(
  parameter int DATA_W = 64,
  parameter int MASK_W = DATA_W/8
) (
  input  mem_op_enum        op,
  input  logic              we,
  input  logic [2:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] st_data,
  output logic [MASK_W-1:0] st_mask,
  output logic [DATA_W-1:0] ld_data
);

  logic [5:0]        shamt;
  logic [7:0]        base;
  logic [DATA_W-1:0] byte_sel;
  logic [DATA_W-1:0] raw;

  always_comb begin
    shamt = {off, 3'b000};
    base  = mask_base(op);
    for (int i = 0; i < 8; i++) byte_sel[i*8 +: 8] = {8{base[i]}};
    // Lanes pushed past byte 7 by the shift simply fall off the bus.
    st_data = we ? ((wdata & byte_sel) << shamt) : '0;
    st_mask = we ? MASK_W'(base << off) : '0;
    raw     = rdata >> shamt;
    case (op)
      MEM_B:   ld_data = {{56{raw[7]}},  raw[7:0]};
      MEM_H:   ld_data = {{48{raw[15]}}, raw[15:0]};
      MEM_W:   ld_data = {{32{raw[31]}}, raw[31:0]};
      MEM_UB:  ld_data = {56'd0, raw[7:0]};
      MEM_UH:  ld_data = {48'd0, raw[15:0]};
      MEM_UW:  ld_data = {32'd0, raw[31:0]};
      MEM_D:   ld_data = raw;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: one outstanding access, valid/ready to dmem.
// Optional misaligned-access trap enabled by DMEM_MISALIGN_CHECK_EN.
import dmem_access_ctrl_pkg::*;

module dmem_access_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MASK_W = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  mem_op_enum        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              misalign,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [MASK_W-1:0] dmem_wmask,
  input  logic              dmem_resp_valid,
  input  logic [DATA_W-1:0] dmem_rdata
);

  dmem_ctrl_state_enum state_q, state_d;
  logic              we_q, we_d;
  mem_op_enum        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] ld_data;
  logic              accept;
  logic              mis_req;

  assign accept = (state_q == ST_IDLE) && req_valid && (req_op != MEM_NO);

`ifdef DMEM_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign mis_req  = is_misaligned(req_op, req_addr[2:0]);
  assign mis_d    = accept ? mis_req : mis_q;
  assign misalign = (state_q == ST_DONE) && mis_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
`else
  assign mis_req  = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      op_q    <= MEM_NO;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = mis_req ? ST_DONE : ST_REQ;
      ST_REQ:  if (dmem_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (dmem_resp_valid) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      we_d    = req_we;
      op_d    = req_op;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      if (mis_req) rdata_d = '0;
    end
    // Stores report zero; the result register otherwise holds until the next DONE.
    if (state_q == ST_WAIT && dmem_resp_valid) rdata_d = we_q ? '0 : ld_data;
  end

  always_comb begin
    req_ready      = 1'b0;
    dmem_req_valid = 1'b0;
    resp_valid     = 1'b0;
    stall          = accept;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_REQ:  begin dmem_req_valid = 1'b1; stall = 1'b1; end
      ST_WAIT: stall = 1'b1;
      ST_DONE: resp_valid = 1'b1;
      default: ;
    endcase
  end

  mem_align_unit #(.DATA_W(DATA_W), .MASK_W(MASK_W)) u_align (
    .op      (op_q),
    .we      (we_q),
    .off     (addr_q[2:0]),
    .wdata   (wdata_q),
    .rdata   (dmem_rdata),
    .st_data (dmem_wdata),
    .st_mask (dmem_wmask),
    .ld_data (ld_data)
  );

  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl: byte-level reference model plus
// per-cycle expectations derived from the access timeline.
`timescale 1ns/1ps
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  mem_op_enum  req_op;
  logic [63:0] req_addr, req_wdata;
  logic        req_ready, stall, resp_valid, misalign;
  logic [63:0] resp_rdata;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_resp_valid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wmask;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .misalign(misalign),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_resp_valid(dmem_resp_valid),
    .dmem_rdata(dmem_rdata)
  );

  int n_chk = 0, n_fail = 0;
  bit pins_done = 1'b0;
  bit chk_en = 1'b0;
  logic e_ready, e_stall, e_dreq, e_resp, e_mis, e_bus_zero, e_we;
  logic [63:0] e_addr, e_wdata, e_rdata;
  logic [7:0]  e_wmask;

  // ---------------- reference model ----------------
  function automatic int nbytes(mem_op_enum op);
    case (op)
      MEM_B, MEM_UB: return 1;
      MEM_H, MEM_UH: return 2;
      MEM_W, MEM_UW: return 4;
      MEM_D:         return 8;
      default:       return 0;
    endcase
  endfunction

  function automatic logic [63:0] m_store_data(mem_op_enum op, logic [63:0] addr, logic [63:0] wd);
    logic [63:0] r;
    int off;
    r = '0;
    off = int'(addr[2:0]);
    for (int b = 0; b < nbytes(op); b++)
      if (off + b < 8) r[(off+b)*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [7:0] m_store_mask(mem_op_enum op, logic [63:0] addr);
    logic [7:0] m;
    int off;
    m = '0;
    off = int'(addr[2:0]);
    for (int b = 0; b < nbytes(op); b++)
      if (off + b < 8) m[off+b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_load(mem_op_enum op, logic [63:0] addr, logic [63:0] rd);
    logic [63:0] r;
    int off, n;
    r = '0;
    off = int'(addr[2:0]);
    n = nbytes(op);
    for (int b = 0; b < n; b++)
      if (off + b < 8) r[b*8 +: 8] = rd[(off+b)*8 +: 8];
    if ((op == MEM_B || op == MEM_H || op == MEM_W) && r[n*8-1])
      for (int b = n; b < 8; b++) r[b*8 +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic m_misaligned(mem_op_enum op, logic [63:0] addr);
`ifdef DMEM_MISALIGN_CHECK_EN
    int n;
    n = nbytes(op);
    return (n > 1) && ((int'(addr[2:0]) % n) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!pins_done) begin
      pins_done = 1'b1;
      chk("pin_stb_data", m_store_data(MEM_B, 64'h1003, 64'hAB), 64'h00000000AB000000);
      chk("pin_stb_mask", 64'(m_store_mask(MEM_B, 64'h1003)), 64'h08);
      chk("pin_ldh",  m_load(MEM_H,  64'h2006, 64'h8001000000000000), 64'hFFFFFFFFFFFF8001);
      chk("pin_lduh", m_load(MEM_UH, 64'h2006, 64'h8001000000000000), 64'h0000000000008001);
      chk("pin_stw_mask", 64'(m_store_mask(MEM_W, 64'h3002)), 64'h3C);
    end
    if (chk_en) begin
      chk("req_ready", req_ready, e_ready);
      chk("stall", stall, e_stall);
      chk("dmem_req_valid", dmem_req_valid, e_dreq);
      chk("resp_valid", resp_valid, e_resp);
      chk("misalign", misalign, e_mis);
      chk("resp_rdata", resp_rdata, e_rdata);
      if (e_dreq) begin
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_we", dmem_we, e_we);
        chk("dmem_wmask", 64'(dmem_wmask), 64'(e_wmask));
        if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      if (e_bus_zero) begin
        chk("rst_addr", dmem_addr, 64'd0);
        chk("rst_wdata", dmem_wdata, 64'd0);
        chk("rst_wmask", 64'(dmem_wmask), 64'd0);
        chk("rst_we", dmem_we, 1'b0);
      end
    end
  end

  // ---------------- driver ----------------
  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_req();
    req_we = 1'($urandom); req_op = mem_op_enum'($urandom_range(0, 7));
    req_addr = r64(); req_wdata = r64();
  endtask

  task automatic set_idle_exp();
    e_ready = 1'b1; e_stall = 1'b0; e_dreq = 1'b0; e_resp = 1'b0; e_mis = 1'b0;
  endtask

  task automatic idle_cyc();
    req_valid = 1'b0; junk_req();
    dmem_req_ready = 1'($urandom); dmem_resp_valid = 1'($urandom); dmem_rdata = r64();
    set_idle_exp(); e_bus_zero = 1'b0;
    step();
  endtask

  task automatic access(logic we, mem_op_enum op, logic [63:0] addr, logic [63:0] wd,
                        logic [63:0] rd, int nrdy, int nwt);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    dmem_req_ready = 1'($urandom); dmem_resp_valid = 1'($urandom); dmem_rdata = r64();
    set_idle_exp(); e_bus_zero = 1'b0; e_stall = (op != MEM_NO);
    step();
    req_valid = 1'b0; junk_req();
    if (op == MEM_NO) return;
    e_ready = 1'b0;
    if (m_misaligned(op, addr)) begin
      dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
      e_stall = 1'b0; e_resp = 1'b1; e_mis = 1'b1; e_rdata = '0;
      step();
      return;
    end
    e_we = we; e_addr = {addr[63:3], 3'b000};
    e_wdata = m_store_data(op, addr, wd);
    e_wmask = we ? m_store_mask(op, addr) : 8'h00;
    e_stall = 1'b1; e_dreq = 1'b1;
    for (int i = 0; i <= nrdy; i++) begin
      dmem_req_ready = (i == nrdy); dmem_resp_valid = 1'b0;
      step();
    end
    e_dreq = 1'b0;
    for (int j = 0; j <= nwt; j++) begin
      dmem_req_ready = 1'($urandom);
      dmem_resp_valid = (j == nwt);
      dmem_rdata = (j == nwt) ? rd : r64();
      step();
    end
    dmem_resp_valid = 1'b0; dmem_rdata = r64();
    // Requests offered during DONE must be ignored.
    req_valid = 1'($urandom);
    e_stall = 1'b0; e_resp = 1'b1; e_rdata = we ? 64'd0 : m_load(op, addr, rd);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = MEM_NO;
    req_addr = '0; req_wdata = '0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = '0;
    set_idle_exp(); e_bus_zero = 1'b1; e_rdata = '0; e_we = 1'b0;
    e_addr = '0; e_wdata = '0; e_wmask = '0;
    chk_en = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // directed cases
    access(1'b1, MEM_B,  64'h1003, 64'hAB, 64'd0, 0, 1);
    access(1'b0, MEM_H,  64'h2006, r64(), 64'h8001000000000000, 0, 0);
    idle_cyc();
    access(1'b0, MEM_UH, 64'h2006, r64(), 64'h8001000000000000, 1, 2);
    access(1'b0, MEM_D,  64'h4000, r64(), 64'h0123456789ABCDEF, 4, 0);
    access(1'b1, MEM_NO, 64'h5000, r64(), r64(), 0, 0);
    access(1'b0, MEM_NO, 64'h5008, r64(), r64(), 0, 0);
    access(1'b1, MEM_W,  64'h3002, 64'hDEADBEEF, 64'd0, 0, 0);
    access(1'b0, MEM_D,  64'h3003, r64(), r64(), 0, 0);

    // reset while in WAIT, then a stale ack
    req_valid = 1'b1; req_we = 1'b0; req_op = MEM_D; req_addr = 64'h6000; req_wdata = r64();
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    set_idle_exp(); e_bus_zero = 1'b0; e_stall = 1'b1;
    step();
    req_valid = 1'b0; dmem_req_ready = 1'b1;
    e_ready = 1'b0; e_dreq = 1'b1; e_we = 1'b0; e_addr = 64'h6000; e_wmask = 8'h00;
    step();
    dmem_req_ready = 1'b0; e_dreq = 1'b0;
    step();
    rst = 1'b1;
    set_idle_exp(); e_bus_zero = 1'b1; e_rdata = '0;
    step();
    rst = 1'b0; dmem_resp_valid = 1'b1; dmem_rdata = r64();
    step();
    dmem_resp_valid = 1'b0;
    step();
    e_bus_zero = 1'b0;

    // randomized traffic
    for (int t = 0; t < 250; t++) begin
      logic [63:0] a;
      a = r64();
      if (t % 4 == 0) a[2:0] = 3'b000;
      access(1'($urandom), mem_op_enum'($urandom_range(0, 7)), a, r64(), r64(),
             $urandom_range(0, 3), $urandom_range(0, 3));
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cyc();
    end
    idle_cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
